// File: rtl/conv3x3_engine_if.sv
// Bus between the top-level controller and the 3x3 convolution engine:
// run request, flattened activation/weight/bias inputs, status and results.
interface conv3x3_engine_if #(
    parameter int IN_H = 14,
    parameter int IN_W = 13,
    parameter int CIN  = 10
);
    localparam int OUT_H = IN_H - 2;
    localparam int OUT_W = IN_W - 2;
    localparam int N_PIX = OUT_H * OUT_W;
    localparam int TAPS  = CIN * 9;

    logic                              start;
    logic [CIN*IN_H*IN_W-1:0][7:0]     in_fmap;
    logic [TAPS-1:0][7:0]              w_flat;
    logic [15:0]                       bias;
    logic                              busy;
    logic                              done;
    logic                              out_valid;
    logic [N_PIX-1:0][7:0]             out_fmap;

    modport master (
        output start, in_fmap, w_flat, bias,
        input  busy, done, out_valid, out_fmap
    );

    modport slave (
        input  start, in_fmap, w_flat, bias,
        output busy, done, out_valid, out_fmap
    );
endinterface

// File: rtl/conv3x3_engine.sv
// Sequential single-output-channel 3x3 valid convolution. One MAC per cycle
// over CIN channels (c outer, ky, kx inner), then bias, ReLU, arithmetic
// shift and 8-bit saturation into the output feature map.
module conv3x3_engine #(
    parameter int IN_H  = 14,
    parameter int IN_W  = 13,
    parameter int CIN   = 10,
    parameter int ACC_W = 24,
    parameter int SHIFT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    conv3x3_engine_if.slave   bus
);
    localparam int OUT_H = IN_H - 2;
    localparam int OUT_W = IN_W - 2;
    localparam int N_PIX = OUT_H * OUT_W;
    localparam int TAPS  = CIN * 9;
    localparam int FM_N  = CIN * IN_H * IN_W;
    localparam int FM_IW = $clog2(FM_N);
    localparam int W_IW  = $clog2(TAPS);
    localparam int PX_IW = $clog2(N_PIX);
    localparam int C_W   = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int OX_W  = $clog2(OUT_W);
    localparam int OY_W  = $clog2(OUT_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [C_W-1:0]          c_r;
    logic [1:0]              ky_r;
    logic [1:0]              kx_r;
    logic [OX_W-1:0]         ox_r;
    logic [OY_W-1:0]         oy_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    valid_r;
    logic [N_PIX-1:0][7:0]   out_r;

    logic [FM_IW-1:0]        fm_idx_s;
    logic [W_IW-1:0]         w_idx_s;
    logic [PX_IW-1:0]        pix_idx_s;
    logic [7:0]              act_s;
    logic [7:0]              wt_s;
    logic signed [16:0]      prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W:0]   v_s;
    logic signed [ACC_W:0]   sh_s;
    logic [7:0]              pix_s;

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_valid = valid_r;
    assign bus.out_fmap  = out_r;

    // Tap addressing, signed product, and bias/ReLU/shift/saturate of the finished sum.
    always_comb begin
        fm_idx_s   = FM_IW'(32'(c_r) * 32'(IN_H * IN_W)
                          + (32'(oy_r) + 32'(ky_r)) * 32'(IN_W)
                          + 32'(ox_r) + 32'(kx_r));
        w_idx_s    = W_IW'(32'(c_r) * 32'd9 + 32'(ky_r) * 32'd3 + 32'(kx_r));
        pix_idx_s  = PX_IW'(32'(oy_r) * 32'(OUT_W) + 32'(ox_r));
        act_s      = bus.in_fmap[fm_idx_s];
        wt_s       = bus.w_flat[w_idx_s];
        prod_s     = $signed({1'b0, act_s}) * $signed(wt_s);
        prod_ext_s = {{(ACC_W-17){prod_s[16]}}, prod_s};
        v_s        = $signed({acc_r[ACC_W-1], acc_r})
                   + $signed({{(ACC_W+1-16){bus.bias[15]}}, bus.bias});
        sh_s       = v_s >>> SHIFT;
        if (v_s[ACC_W] || (v_s == '0)) begin
            pix_s = 8'd0;
        end else if (sh_s[ACC_W:8] != '0) begin
            pix_s = 8'd255;
        end else begin
            pix_s = sh_s[7:0];
        end
    end

    // Control FSM with accumulator, tap/pixel counters and result storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            acc_r   <= '0;
            c_r     <= '0;
            ky_r    <= 2'd0;
            kx_r    <= 2'd0;
            ox_r    <= '0;
            oy_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            out_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // done_r high here means start coincides with the done pulse
                    if (bus.start && !done_r) begin
                        state_r <= S_MAC;
                        acc_r   <= '0;
                        c_r     <= '0;
                        ky_r    <= 2'd0;
                        kx_r    <= 2'd0;
                        ox_r    <= '0;
                        oy_r    <= '0;
                        busy_r  <= 1'b1;
                        valid_r <= 1'b0;
                    end
                end
                S_MAC: begin
                    acc_r <= acc_r + prod_ext_s;
                    if (kx_r == 2'd2) begin
                        kx_r <= 2'd0;
                        if (ky_r == 2'd2) begin
                            ky_r <= 2'd0;
                            if (c_r == C_W'(CIN - 1)) begin
                                c_r     <= '0;
                                state_r <= S_WRITE;
                            end else begin
                                c_r <= c_r + C_W'(1);
                            end
                        end else begin
                            ky_r <= ky_r + 2'd1;
                        end
                    end else begin
                        kx_r <= kx_r + 2'd1;
                    end
                end
                S_WRITE: begin
                    out_r[pix_idx_s] <= pix_s;
                    acc_r            <= '0;
                    state_r          <= S_MAC;
                    if (ox_r == OX_W'(OUT_W - 1)) begin
                        ox_r <= '0;
                        if (oy_r == OY_W'(OUT_H - 1)) begin
                            oy_r    <= '0;
                            busy_r  <= 1'b0;
                            state_r <= S_DONE;
                        end else begin
                            oy_r <= oy_r + OY_W'(1);
                        end
                    end else begin
                        ox_r <= ox_r + OX_W'(1);
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b1;
                    valid_r <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: expected pixels come from a plain
// integer convolution model, are queued at start and popped after done.
module tb_conv3x3_engine;
    localparam int IN_H  = 14;
    localparam int IN_W  = 13;
    localparam int CIN   = 10;
    localparam int OUT_H = IN_H - 2;
    localparam int OUT_W = IN_W - 2;
    localparam int N_PIX = OUT_H * OUT_W;
    localparam int TAPS  = CIN * 9;
    localparam int FM_N  = CIN * IN_H * IN_W;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   exp_q[$];

    conv3x3_engine_if #(.IN_H(IN_H), .IN_W(IN_W), .CIN(CIN)) bif ();

    conv3x3_engine #(.IN_H(IN_H), .IN_W(IN_W), .CIN(CIN), .ACC_W(24), .SHIFT(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int model_pix(input int oy, input int ox);
        int sum;
        int v;
        sum = 0;
        for (int c = 0; c < CIN; c++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    sum += int'(bif.in_fmap[c*IN_H*IN_W + (oy+ky)*IN_W + (ox+kx)])
                         * int'($signed(bif.w_flat[c*9 + ky*3 + kx]));
        v = sum + int'($signed(bif.bias));
        if (v <= 0) return 0;
        if ((v >>> 7) > 255) return 255;
        return v >>> 7;
    endfunction

    task automatic push_expected();
        for (int oy = 0; oy < OUT_H; oy++)
            for (int ox = 0; ox < OUT_W; ox++)
                exp_q.push_back(model_pix(oy, ox));
    endtask

    task automatic set_all(input int a, input int w, input int b);
        for (int i = 0; i < FM_N; i++) bif.in_fmap[i] = 8'(a);
        for (int i = 0; i < TAPS; i++) bif.w_flat[i] = 8'(w);
        bif.bias = 16'(b);
    endtask

    function automatic int nonzero_outputs();
        int n;
        n = 0;
        for (int p = 0; p < N_PIX; p++) if (bif.out_fmap[p] != 8'd0) n++;
        return n;
    endfunction

    // Full run: timing of busy/done, optional stray starts, then pixel compare.
    task automatic run_full(input string tag, input bit extra);
        int busy_cnt;
        int done_cnt;
        int done_k;
        int expv;
        busy_cnt = 0;
        done_cnt = 0;
        done_k   = -1;
        push_expected();
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 12030; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bif.start = 1'b0;
                check({tag, "_valid_drop"}, 32'(bif.out_valid), 32'd0);
                check({tag, "_busy_rise"}, 32'(bif.busy), 32'd1);
            end
            if (extra) begin
                if (k == 9 || k == 12012) bif.start = 1'b1;
                else if (k == 10 || k == 12014) bif.start = 1'b0;
            end
            if (bif.busy) busy_cnt++;
            if (bif.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
        end
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_latency"}, 32'(done_k), 32'd12013);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd12012);
        check({tag, "_valid_end"}, 32'(bif.out_valid), 32'd1);
        check({tag, "_busy_end"}, 32'(bif.busy), 32'd0);
        for (int p = 0; p < N_PIX; p++) begin
            expv = exp_q.pop_front();
            check($sformatf("%s_pix%0d", tag, p), 32'(bif.out_fmap[p]), 32'(expv));
        end
    endtask

    initial begin
        int done_seen;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bif.start   = 1'b0;
        set_all(0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_done", 32'(bif.done), 32'd0);
        check("rst_valid", 32'(bif.out_valid), 32'd0);
        check("rst_out_zero", 32'(nonzero_outputs()), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Uniform 128 x weight 1 -> 90, with starts while busy and at done.
        set_all(128, 1, 0);
        run_full("ones", 1'b1);

        // Restart after done: w=-1 with large positive bias -> 23767>>>7 = 185.
        set_all(100, -1, 32767);
        run_full("bias185", 1'b0);

        // Two isolated impulses, channel 0 centre and channel 9 centre weights.
        set_all(0, 0, 0);
        bif.in_fmap[0*IN_H*IN_W + 5*IN_W + 5] = 8'd200;
        bif.w_flat[4]                         = 8'd64;
        bif.in_fmap[9*IN_H*IN_W + 2*IN_W + 3] = 8'd200;
        bif.w_flat[85]                        = 8'd64;
        run_full("impulse", 1'b0);

        // Maximum positive products saturate every pixel to 255.
        set_all(255, 127, 0);
        run_full("sat", 1'b0);

        // Abort a bias-only run (every pixel 2) by reset at cycle 5000.
        set_all(0, 0, 256);
        done_seen = 0;
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (k == 0) bif.start = 1'b0;
            if (bif.done) done_seen++;
        end
        check("abort_progress", 32'(bif.out_fmap[0]), 32'd2);
        check("abort_untouched", 32'(bif.out_fmap[N_PIX-1]), 32'd255);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bif.busy), 32'd0);
        check("abort_done", 32'(bif.done), 32'd0);
        check("abort_valid", 32'(bif.out_valid), 32'd0);
        check("abort_out_zero", 32'(nonzero_outputs()), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bif.done) done_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bif.done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Fresh run after reset with random activations, weights and bias.
        for (int i = 0; i < FM_N; i++) bif.in_fmap[i] = 8'($urandom_range(255, 0));
        for (int i = 0; i < TAPS; i++) bif.w_flat[i] = 8'($urandom_range(255, 0));
        bif.bias = 16'($urandom_range(65535, 0));
        run_full("random", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
Sequential single-output-channel 3x3 valid convolution stage that produces the 12x11 feature map consumed by the fully-connected stage (flattened row-major into its 132-entry input vector). It MACs CIN input channels, one tap per cycle, then adds bias, applies ReLU, right-shifts and saturates to 8 bits. The top-level controller loads activations and weights, then pulses start.

Parameters:
IN_H, 14, input feature-map height
IN_W, 13, input feature-map width
CIN, 10, input channels accumulated into the single output channel
ACC_W, 24, signed accumulator width
SHIFT, 7, arithmetic right shift applied before saturation
(derived, not overridable) OUT_H = IN_H-2, OUT_W = IN_W-2, N_PIX = OUT_H*OUT_W, TAPS = CIN*9

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle run request
in_fmap  in  8 x CIN*IN_H*IN_W  unsigned activations; index c*IN_H*IN_W + y*IN_W + x
w_flat  in  8 x TAPS  signed weights; index c*9 + ky*3 + kx
bias  in  16  signed bias, sign-extended to ACC_W
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse when the last pixel is written
out_valid  out  1  high from done until the next accepted start
out_fmap  out  8 x N_PIX  unsigned results; index oy*OUT_W + ox

Behaviour:
- Reset: busy=0, done=0, out_valid=0, accumulator=0, all counters=0, every out_fmap entry=0, state=S_IDLE.
- FSM states: S_IDLE, S_MAC, S_WRITE, S_DONE.
- S_IDLE: start=1 -> S_MAC; clear the accumulator and pixel/tap counters; busy=1 and out_valid=0 from the next cycle.
- S_MAC: one tap per cycle, with tap order c outer, then ky, then kx.
  - acc += zero-extended in_fmap[c][oy+ky][ox+kx] times signed w_flat[c*9+ky*3+kx].
  - Product is 17-bit signed, sign-extended to ACC_W.
  - After TAPS cycles -> S_WRITE.
- S_WRITE (1 cycle):
  - v = acc + bias.
  - v <= 0 -> out_fmap[oy*OUT_W+ox] = 0.
  - Otherwise the entry is min(v >>> SHIFT, 255).
  - Clear acc and advance ox, wrapping to 0 with oy+1.
  - Last pixel -> S_DONE; otherwise -> S_MAC.
- S_DONE (1 cycle): done=1, busy=0, out_valid=1 -> S_IDLE.
- Latency: with start sampled at cycle t, pixel p is written at t+(p+1)*(TAPS+1), and done is high at t+N_PIX*(TAPS+1)+1. With defaults that is 12013 cycles.
- start while busy (S_MAC/S_WRITE/S_DONE) is ignored with no restart. start in the same cycle as done is ignored.
- out_fmap entries update progressively during a run and are only meaningful while out_valid=1. Entries not yet rewritten keep their previous values.
- in_fmap, w_flat and bias must be held stable by the caller while busy. The block does not latch them.
- ACC_W=24 is sufficient for defaults: the worst case of 90*255*128 = 2,937,600 does not overflow. No overflow detection is required.
- Reset asserted mid-run: immediate return to the reset values. done never pulses for the aborted run.

Test Plan:
1. All in_fmap=128, all w=1, bias=0, start -> every out_fmap entry=90; done exactly 12013 cycles after start; busy high for 12012 cycles.
2. All in_fmap=100, all w=-1, bias=0 -> every out_fmap entry=0 (ReLU). Same input with bias=+32767 -> v=23767, >>7=185, every entry=185.
3. All in_fmap=255, all w=127 -> every entry saturates to 255. in_fmap=0 with bias=256 -> every entry=2. in_fmap=0 with bias=-128 -> every entry=0.
4. Single in_fmap[c=0,y=5,x=5]=200, only w_flat[4] (c0 centre)=64, others 0 -> out_fmap[4*11+4]=100, all 131 other entries 0. The same pixel on c=9 with w_flat[85]=64 gives the same result.
5. Pulse start again at cycles 10 and 12013 after the first start (while busy / coincident with done) -> no restart, exactly one done pulse. A start after done restarts, drops out_valid, and produces a second done 12013 cycles later.
6. Assert rst_n low at cycle 5000 of a run -> busy, done, out_valid and all out_fmap return to 0 asynchronously, with no done pulse. A fresh start after release completes normally with correct results.
